// File: rtl/ctrl_pkt_decoder_pkg.sv
// Shared constants, entry type and mask helpers for the control-packet decoder.
package ctrl_pkt_decoder_pkg;

  localparam int MOD_ID_LSB      = 368;
  localparam int RES_ID_LSB      = 376;
  localparam int ADDR_HI_LSB     = 384;
  localparam int ADDR_LO_LSB     = 392;
  localparam int CFG_DATA_WIDTH  = 128;
  localparam int CHUNKS_PER_BEAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BODY    = 2'd1,
    ST_DISCARD = 2'd2
  } in_state_t;

  typedef logic [CHUNKS_PER_BEAT-1:0] chunk_mask_t;

  typedef struct packed {
    logic [7:0]                                       mod_id;
    logic [7:0]                                       res_id;
    logic [15:0]                                      start_addr;
    logic [CHUNKS_PER_BEAT-1:0][CFG_DATA_WIDTH-1:0]   data;
    chunk_mask_t                                      mask;
  } beat_ent_t;

  // Index of the lowest set chunk; chunks are emitted low to high.
  function automatic logic [1:0] first_chunk(input chunk_mask_t m);
    first_chunk = 2'd0;
    for (int k = CHUNKS_PER_BEAT - 1; k >= 0; k--) begin
      if (m[k]) first_chunk = 2'(k);
    end
  endfunction

  function automatic logic [15:0] chunk_count(input chunk_mask_t m);
    chunk_count = '0;
    for (int k = 0; k < CHUNKS_PER_BEAT; k++) begin
      chunk_count = chunk_count + {15'd0, m[k]};
    end
  endfunction

endpackage

// File: rtl/ctrl_beat_fifo.sv
// Show-ahead FIFO: head is on rd_data while not empty; latency 1 cycle write-to-visible.
// Writes while full and reads while empty are ignored; simultaneous write and pop allowed.
module ctrl_beat_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

endmodule

// File: rtl/ctrl_pkt_decoder.sv
// Decodes control packets into 128-bit table writes; beat-to-write latency 2 cycles when idle.
// Input cannot stall: beats that find the buffer full truncate the packet and bump drop_cnt.
module ctrl_pkt_decoder
  import ctrl_pkt_decoder_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     c_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   c_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    c_s_axis_tuser,
  input  logic                               c_s_axis_tvalid,
  input  logic                               c_s_axis_tlast,
  output logic                               cfg_wr_en,
  input  logic                               cfg_wr_ready,
  output logic [7:0]                         cfg_mod_id,
  output logic [7:0]                         cfg_res_id,
  output logic [15:0]                        cfg_addr,
  output logic [CFG_DATA_WIDTH-1:0]          cfg_wr_data,
  output logic [15:0]                        drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);
  localparam int ENT_W = $bits(beat_ent_t);

  in_state_t   state;
  logic [7:0]  hdr_mod_id;
  logic [7:0]  hdr_res_id;
  logic [15:0] next_addr;
  chunk_mask_t beat_mask;
  beat_ent_t   wr_ent;
  beat_ent_t   head_ent;
  logic [ENT_W-1:0] head_raw;
  logic        fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic        in_full, body_beat;
  logic [AW:0] fifo_count, occupancy;
  logic        unused_tuser;

  assign unused_tuser = ^c_s_axis_tuser;

  always_comb begin
    beat_mask = '0;
    for (int k = 0; k < CHUNKS_PER_BEAT; k++) begin
      beat_mask[k] = &c_s_axis_tkeep[16*k +: 16];
    end
  end

  // The entry held by the serialiser still counts against capacity until its last chunk is accepted.
  assign occupancy = fifo_count + {{AW{1'b0}}, cfg_wr_en};
  assign in_full   = fifo_full || (occupancy >= FULL_OCC);
  assign body_beat = c_s_axis_tvalid && (state == ST_BODY);
  assign fifo_wr   = body_beat && !in_full && (beat_mask != '0);

  always_comb begin
    wr_ent            = '0;
    wr_ent.mod_id     = hdr_mod_id;
    wr_ent.res_id     = hdr_res_id;
    wr_ent.start_addr = next_addr;
    wr_ent.data       = c_s_axis_tdata;
    wr_ent.mask       = beat_mask;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      hdr_mod_id <= '0;
      hdr_res_id <= '0;
      next_addr  <= '0;
      drop_cnt   <= '0;
    end else if (c_s_axis_tvalid) begin
      case (state)
        ST_IDLE: begin
          hdr_mod_id <= c_s_axis_tdata[MOD_ID_LSB +: 8];
          hdr_res_id <= c_s_axis_tdata[RES_ID_LSB +: 8];
          next_addr  <= {c_s_axis_tdata[ADDR_HI_LSB +: 8], c_s_axis_tdata[ADDR_LO_LSB +: 8]};
          if (!c_s_axis_tlast) state <= ST_BODY;
        end
        ST_BODY: begin
          if (in_full) begin
            if (drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
            state <= c_s_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else begin
            next_addr <= next_addr + chunk_count(beat_mask);
            if (c_s_axis_tlast) state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (c_s_axis_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ctrl_beat_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .wr_en   (fifo_wr),
    .wr_data (wr_ent),
    .rd_en   (fifo_rd),
    .rd_data (head_raw),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_ent = beat_ent_t'(head_raw);

  chunk_mask_t rem_mask;
  logic [CHUNKS_PER_BEAT-1:0][CFG_DATA_WIDTH-1:0] cur_data;
  logic        advance;
  logic [1:0]  rem_idx, head_idx;

  assign advance  = !cfg_wr_en || cfg_wr_ready;
  assign rem_idx  = first_chunk(rem_mask);
  assign head_idx = first_chunk(head_ent.mask);
  assign fifo_rd  = advance && (rem_mask == '0) && !fifo_empty;

  // rem_mask holds chunks of the current beat not yet presented on the cfg port.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_wr_en   <= 1'b0;
      cfg_mod_id  <= '0;
      cfg_res_id  <= '0;
      cfg_addr    <= '0;
      cfg_wr_data <= '0;
      rem_mask    <= '0;
      cur_data    <= '0;
    end else if (advance) begin
      if (rem_mask != '0) begin
        cfg_wr_en   <= 1'b1;
        cfg_addr    <= cfg_addr + 16'd1;
        cfg_wr_data <= cur_data[rem_idx];
        rem_mask    <= rem_mask & (rem_mask - 1'b1);
      end else if (!fifo_empty) begin
        cfg_wr_en   <= 1'b1;
        cfg_mod_id  <= head_ent.mod_id;
        cfg_res_id  <= head_ent.res_id;
        cfg_addr    <= head_ent.start_addr;
        cfg_wr_data <= head_ent.data[head_idx];
        cur_data    <= head_ent.data;
        rem_mask    <= head_ent.mask & (head_ent.mask - 1'b1);
      end else begin
        cfg_wr_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pkt_decoder.sv
// Randomised and directed bench for ctrl_pkt_decoder against a packet-level write model.
module tb_ctrl_pkt_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aresetn;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic [127:0] tuser;
  logic         tvalid, tlast;
  logic         cfg_wr_en, cfg_wr_ready;
  logic [7:0]   cfg_mod_id, cfg_res_id;
  logic [15:0]  cfg_addr, drop_cnt;
  logic [127:0] cfg_wr_data;

  ctrl_pkt_decoder dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .c_s_axis_tdata  (tdata),
    .c_s_axis_tkeep  (tkeep),
    .c_s_axis_tuser  (tuser),
    .c_s_axis_tvalid (tvalid),
    .c_s_axis_tlast  (tlast),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_ready    (cfg_wr_ready),
    .cfg_mod_id      (cfg_mod_id),
    .cfg_res_id      (cfg_res_id),
    .cfg_addr        (cfg_addr),
    .cfg_wr_data     (cfg_wr_data),
    .drop_cnt        (drop_cnt)
  );

  typedef struct packed {
    logic [7:0]   mod;
    logic [7:0]   res;
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t  cur;
  assign cur = {cfg_mod_id, cfg_res_id, cfg_addr, cfg_wr_data};

  wr_t          expq[$];
  int           checks = 0;
  int           errors = 0;
  int           writes_seen = 0;
  int           rmode = 1;
  logic [511:0] pd [8];
  logic [63:0]  pk [8];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] rand_keep();
    logic [63:0] k;
    k = '0;
    for (int c = 0; c < 4; c++) begin
      case ($urandom_range(0, 3))
        0, 1:    k[16*c +: 16] = 16'hffff;
        2:       k[16*c +: 16] = 16'h0000;
        default: k[16*c +: 16] = 16'($urandom_range(1, 16'hfffe));
      endcase
    end
    return k;
  endfunction

  // Expected writes: every fully-kept 128-bit chunk of accepted beats, addresses counting up from base.
  task automatic model_pkt(input logic [7:0] m, input logic [7:0] r, input logic [15:0] base, input int nacc);
    logic [15:0] a;
    a = base;
    for (int b = 0; b < nacc; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (pk[b][16*k +: 16] == 16'hffff) begin
          expq.push_back({m, r, a, pd[b][128*k +: 128]});
          a = a + 16'd1;
        end
      end
    end
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic last);
    tdata  = d;
    tkeep  = k;
    tlast  = last;
    tuser  = {$urandom, $urandom, $urandom, $urandom};
    tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = rand512();
    tkeep  = '0;
  endtask

  task automatic send_hdr(input logic [7:0] m, input logic [7:0] r, input logic [15:0] base, input logic last);
    logic [511:0] h;
    h = rand512();
    h[375:368] = m;
    h[383:376] = r;
    h[391:384] = base[15:8];
    h[399:392] = base[7:0];
    send_beat(h, {64{1'b1}}, last);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", name, expq.size());
      expq.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       cfg_wr_ready = 1'b0;
        1:       cfg_wr_ready = 1'b1;
        default: cfg_wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every accepted write against the model queue; stalled outputs must hold.
  initial begin
    wr_t held;
    wr_t e;
    bit  pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("stall_en", {159'd0, cfg_wr_en}, 160'd1);
          chk("stall_hold", cur, held);
        end
        pend = 0;
        if (cfg_wr_en && cfg_wr_ready) begin
          writes_seen++;
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h required=none", cur);
          end else begin
            e = expq.pop_front();
            chk("write", cur, e);
          end
        end else if (cfg_wr_en) begin
          held = cur;
          pend = 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    aresetn = 1'b0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tdata   = '0;
    tkeep   = '0;
    tuser   = '0;
    rmode   = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_en", {159'd0, cfg_wr_en}, 160'd0);
    chk("rst_fields", cur, 160'd0);
    chk("rst_drop", {144'd0, drop_cnt}, 160'd0);
    aresetn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Full beat, base 0x0010, and the two-cycle latency.
    pd[0] = rand512();
    pk[0] = {64{1'b1}};
    model_pkt(8'h02, 8'h05, 16'h0010, 1);
    chk("m1_size", 160'(expq.size()), 160'd4);
    chk("m1_addr0", {144'd0, expq[0].addr}, 160'h0010);
    chk("m1_addr3", {144'd0, expq[3].addr}, 160'h0013);
    chk("m1_mod", {152'd0, expq[1].mod}, 160'h02);
    chk("m1_data2", {32'd0, expq[2].data}, {32'd0, pd[0][383:256]});
    send_hdr(8'h02, 8'h05, 16'h0010, 1'b0);
    send_beat(pd[0], pk[0], 1'b1);
    @(negedge clk);
    chk("lat_n1_en", {159'd0, cfg_wr_en}, 160'd0);
    @(negedge clk);
    chk("lat_n2_en", {159'd0, cfg_wr_en}, 160'd1);
    drain("full_beat");

    // Partial keep: chunks 0 and 2 only.
    pd[0] = rand512();
    pk[0] = 64'h0000_FFFF_0000_FFFF;
    model_pkt(8'h11, 8'h22, 16'h1234, 1);
    chk("m2_size", 160'(expq.size()), 160'd2);
    chk("m2_addr1", {144'd0, expq[1].addr}, 160'h1235);
    chk("m2_data1", {32'd0, expq[1].data}, {32'd0, pd[0][383:256]});
    send_hdr(8'h11, 8'h22, 16'h1234, 1'b0);
    send_beat(pd[0], pk[0], 1'b1);
    drain("partial");

    // Address wrap with random ready.
    rmode = 2;
    for (int b = 0; b < 2; b++) begin
      pd[b] = rand512();
      pk[b] = {64{1'b1}};
    end
    model_pkt(8'h07, 8'h01, 16'hfffe, 2);
    chk("m3_size", 160'(expq.size()), 160'd8);
    chk("m3_addr1", {144'd0, expq[1].addr}, 160'hffff);
    chk("m3_addr2", {144'd0, expq[2].addr}, 160'h0000);
    chk("m3_addr7", {144'd0, expq[7].addr}, 160'h0005);
    send_hdr(8'h07, 8'h01, 16'hfffe, 1'b0);
    send_beat(pd[0], pk[0], 1'b0);
    send_beat(pd[1], pk[1], 1'b1);
    drain("wrap");

    // Overflow: ready low, six back-to-back full beats.
    rmode = 0;
    repeat (2) @(posedge clk); #1;
    for (int b = 0; b < 6; b++) begin
      pd[b] = rand512();
      pk[b] = {64{1'b1}};
    end
    model_pkt(8'h03, 8'h04, 16'h0200, 4);
    chk("m4_size", 160'(expq.size()), 160'd16);
    w0 = writes_seen;
    send_hdr(8'h03, 8'h04, 16'h0200, 1'b0);
    for (int b = 0; b < 6; b++) begin
      send_beat(pd[b], pk[b], b == 5);
      if (b == 3) chk("drop_before", {144'd0, drop_cnt}, 160'd0);
      if (b == 4) chk("drop_after", {144'd0, drop_cnt}, 160'd1);
    end
    repeat (4) @(posedge clk); #1;
    chk("drop_final", {144'd0, drop_cnt}, 160'd1);
    chk("ovf_no_writes", 160'(writes_seen - w0), 160'd0);
    rmode = 1;
    drain("overflow");
    chk("ovf_writes", 160'(writes_seen - w0), 160'd16);

    // Single-beat packet followed by a normal one.
    send_hdr(8'haa, 8'hbb, 16'h0aaa, 1'b1);
    pd[0] = rand512();
    pk[0] = {64{1'b1}};
    model_pkt(8'h33, 8'h44, 16'h0100, 1);
    chk("m5_mod", {152'd0, expq[0].mod}, 160'h33);
    send_hdr(8'h33, 8'h44, 16'h0100, 1'b0);
    send_beat(pd[0], pk[0], 1'b1);
    drain("single_beat");

    // Randomised packets, at most four payload beats so the buffer never overflows.
    rmode = 2;
    for (int p = 0; p < 30; p++) begin
      int n;
      logic [7:0]  m, r;
      logic [15:0] base;
      n    = $urandom_range(0, 4);
      m    = 8'($urandom);
      r    = 8'($urandom);
      base = 16'($urandom);
      for (int b = 0; b < n; b++) begin
        pd[b] = rand512();
        pk[b] = rand_keep();
      end
      model_pkt(m, r, base, n);
      send_hdr(m, r, base, n == 0);
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_beat(pd[b], pk[b], b == n - 1);
      end
      drain("random");
    end
    chk("rand_drop", {144'd0, drop_cnt}, 160'd1);

    // Reset during serialisation.
    rmode = 1;
    for (int b = 0; b < 2; b++) begin
      pd[b] = rand512();
      pk[b] = {64{1'b1}};
    end
    model_pkt(8'h09, 8'h08, 16'h0300, 2);
    send_hdr(8'h09, 8'h08, 16'h0300, 1'b0);
    send_beat(pd[0], pk[0], 1'b0);
    send_beat(pd[1], pk[1], 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_en", {159'd0, cfg_wr_en}, 160'd0);
    chk("mid_rst_fields", cur, 160'd0);
    chk("mid_rst_drop", {144'd0, drop_cnt}, 160'd0);
    expq.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    w0 = writes_seen;
    repeat (20) @(posedge clk); #1;
    chk("post_rst_writes", 160'(writes_seen - w0), 160'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
